slave_out_port: RTL and testbench

//  Slave-side serial transmitter for the serial bus read path. On a read start it fetches

---
 rtl/serial_bus_pkg.sv | 19 +
 rtl/slave_tx_shifter.sv | 33 +++
 rtl/slave_out_port.sv | 134 +++++++++++++
 tb/tb_slave_out_port.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg: shared FSM states, default widths and bus command codes for the serial bus ports.
package serial_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        HANDSHAKE,
        SHIFT,
        DONE
    } state_t;

    localparam int DEF_DATA_LEN  = 8;
    localparam int DEF_BURST_LEN = 12;
    localparam int DEF_ADDR_LEN  = 8;

    localparam logic [1:0] RD_CMD = 2'b11;

endpackage

// File: rtl/slave_tx_shifter.sv
// slave_tx_shifter: LSB-first word shift register with a bit counter that flags the final bit.
module slave_tx_shifter #(
    parameter int DATA_LEN = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic [DATA_LEN-1:0] load_data,
    input  logic                shift,
    output logic                tx,
    output logic                last_bit
);
    localparam int BW = $clog2(DATA_LEN);

    logic [DATA_LEN-1:0] shift_reg;
    logic [BW-1:0]       bit_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (load) begin
            shift_reg <= load_data;
            bit_cnt   <= '0;
        end else if (shift) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + BW'(1);
        end
    end

    assign tx       = shift_reg[0];
    assign last_bit = bit_cnt == BW'(DATA_LEN - 1);
endmodule

// File: rtl/slave_out_port.sv
// slave_out_port: slave read-path serial transmitter, burst of words from storage sent LSB-first.
// Define PREFETCH_EN to fetch the next word during SHIFT and remove the inter-word gap.
module slave_out_port
    import serial_bus_pkg::*;
#(
    parameter int DATA_LEN  = DEF_DATA_LEN,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int ADDR_LEN  = DEF_ADDR_LEN
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_LEN-1:0]  start_addr,
    input  logic [BURST_LEN-1:0] burst_num,
    output logic                 mem_rd_en,
    output logic [ADDR_LEN-1:0]  mem_addr,
    input  logic [DATA_LEN-1:0]  mem_rd_data,
    output logic                 tx_data,
    output logic                 slave_valid,
    input  logic                 master_ready,
    output logic                 busy,
    output logic                 done
);
    state_t               state;
    logic [ADDR_LEN-1:0]  cur_addr;
    logic [BURST_LEN-1:0] burst_q;
    logic [BURST_LEN-1:0] word_cnt;
    logic                 last_bit;
    logic                 final_word;
    logic                 shift_en;
    logic                 load_en;
    logic [DATA_LEN-1:0]  load_data;

    assign final_word = word_cnt == burst_q;
    assign shift_en   = (state == HANDSHAKE && master_ready) || (state == SHIFT && !last_bit);

`ifdef PREFETCH_EN
    logic [DATA_LEN-1:0] hold_reg;
    logic                pf_pend;

    assign load_en   = state == LOAD || (state == SHIFT && last_bit && !final_word);
    assign load_data = state == LOAD ? mem_rd_data : hold_reg;

    // the prefetch read issued in the first SHIFT cycle returns data one cycle later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_reg <= '0;
            pf_pend  <= 1'b0;
        end else begin
            pf_pend <= state == SHIFT && mem_rd_en;
            if (pf_pend)
                hold_reg <= mem_rd_data;
        end
    end
`else
    assign load_en   = state == LOAD;
    assign load_data = mem_rd_data;
`endif

    slave_tx_shifter #(.DATA_LEN(DATA_LEN)) u_shifter (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load_en),
        .load_data (load_data),
        .shift     (shift_en),
        .tx        (tx_data),
        .last_bit  (last_bit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            slave_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cur_addr    <= '0;
            burst_q     <= '0;
            word_cnt    <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cur_addr  <= start_addr;
                    burst_q   <= burst_num;
                    word_cnt  <= '0;
                    mem_rd_en <= 1'b1;
                    mem_addr  <= start_addr;
                    busy      <= 1'b1;
                    state     <= FETCH;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    slave_valid <= 1'b1;
                    state       <= HANDSHAKE;
                end
                HANDSHAKE: if (master_ready) begin
                    slave_valid <= 1'b0;
                    state       <= SHIFT;
`ifdef PREFETCH_EN
                    if (!final_word) begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= cur_addr + ADDR_LEN'(1);
                    end
`endif
                end
                SHIFT: if (last_bit) begin
                    if (final_word) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        word_cnt <= word_cnt + BURST_LEN'(1);
                        cur_addr <= cur_addr + ADDR_LEN'(1);
`ifdef PREFETCH_EN
                        slave_valid <= 1'b1;
                        state       <= HANDSHAKE;
`else
                        mem_rd_en <= 1'b1;
                        mem_addr  <= cur_addr + ADDR_LEN'(1);
                        state     <= FETCH;
`endif
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slave_out_port.sv
// tb_slave_out_port: scoreboard bench; a master model reassembles words and checks them against queued expectations.
module tb_slave_out_port;
    localparam int DW = 8;
    localparam int BL = 12;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          master_ready = 1'b1;
    logic [AW-1:0] start_addr = '0;
    logic [BL-1:0] burst_num = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          tx_data, slave_valid, busy, done;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] exp_q [$];
    int            hs_cyc [$];
    int            n_vec = 0, n_err = 0, cyc = 0, hs_cnt = 0, done_cnt = 0;
    logic [DW-1:0] mon_w;
    bit            mon_ab;
    logic [DW-1:0] t1_word = 8'hA5;
    int            base_hs, base_done, k;

    slave_out_port #(.DATA_LEN(DW), .BURST_LEN(BL), .ADDR_LEN(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .start_addr   (start_addr),
        .burst_num    (burst_num),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .tx_data      (tx_data),
        .slave_valid  (slave_valid),
        .master_ready (master_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en)
            mem_rd_data <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] a, input logic [BL-1:0] b);
        start_addr = a;
        burst_num  = b;
        start      = 1'b1;
        for (int i = 0; i <= int'(b); i++)
            exp_q.push_back(mem[AW'(int'(a) + i)]);
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 300) begin
            cycle();
            n++;
        end
        chk(name, done, 1);
    endtask

    // master model: handshake cycle carries bit0, the next DW-1 cycles carry the rest
    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
        if (reset_n && slave_valid && master_ready) begin
            hs_cnt++;
            hs_cyc.push_back(cyc);
            mon_w[0] = tx_data;
            mon_ab   = 1'b0;
            for (int i = 1; i < DW; i++) begin
                @(negedge clk);
                if (done) done_cnt++;
                if (!reset_n) mon_ab = 1'b1;
                mon_w[i] = tx_data;
            end
            if (!mon_ab) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none", mon_w);
                end else begin
                    chk("word", mon_w, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = AW'(i);
        mem[8'h10] = 8'hA5;
        mem[8'h20] = 8'h01; mem[8'h21] = 8'h80; mem[8'h22] = 8'hFF;
        mem[8'h30] = 8'h6B;
        mem[8'hFF] = 8'h5A; mem[8'h00] = 8'hC3;
        mem[8'h40] = 8'h3C; mem[8'h41] = 8'hC3; mem[8'h42] = 8'h0F; mem[8'h43] = 8'hF0;
        mem[8'h50] = 8'h96;
        mem[8'h60] = 8'h11; mem[8'h61] = 8'h22; mem[8'h70] = 8'hEE;

        cycle();
        cycle();
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_tx", tx_data, 0);
        chk("rst_valid", slave_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset_n = 1'b1;
        cycle();

        do_start(8'h10, 0);
        chk("t1_rd_en", mem_rd_en, 1);
        chk("t1_addr", mem_addr, 8'h10);
        chk("t1_busy", busy, 1);
        chk("t1_valid_t1", slave_valid, 0);
        cycle();
        chk("t1_valid_t2", slave_valid, 0);
        cycle();
        chk("t1_valid_t3", slave_valid, 1);
        chk("t1_bit0", tx_data, t1_word[0]);
        for (int i = 1; i < DW; i++) begin
            cycle();
            chk("t1_valid_low", slave_valid, 0);
            chk("t1_bit", tx_data, t1_word[i]);
        end
        cycle();
        chk("t1_done", done, 1);
        chk("t1_busy_done", busy, 1);
        cycle();
        chk("t1_done_clear", done, 0);
        chk("t1_idle", busy, 0);

        base_hs = hs_cnt;
        base_done = done_cnt;
        do_start(8'h20, 2);
        wait_done("t2_done");
        cycle();
        cycle();
        chk("t2_handshakes", hs_cnt - base_hs, 3);
        chk("t2_done_pulses", done_cnt - base_done, 1);

        master_ready = 1'b0;
        do_start(8'h30, 0);
        k = 0;
        while (!slave_valid && k < 20) begin
            cycle();
            k++;
        end
        chk("t3_valid_seen", slave_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", slave_valid, 1);
            chk("t3_hold_tx", tx_data, 1);
            cycle();
        end
        master_ready = 1'b1;
        wait_done("t3_done");
        cycle();

        hs_cyc.delete();
        do_start(8'hFF, 1);
        wait_done("t4_done");
        cycle();
        chk("t4_handshakes", hs_cyc.size(), 2);
        if (hs_cyc.size() >= 2)
`ifdef PREFETCH_EN
            chk("t4_gap", hs_cyc[1] - hs_cyc[0], 8);
`else
            chk("t4_gap", hs_cyc[1] - hs_cyc[0], 10);
`endif

        base_hs = hs_cnt;
        do_start(8'h40, 3);
        k = 0;
        while (hs_cnt < base_hs + 2 && k < 100) begin
            cycle();
            k++;
        end
        chk("t5_word1_reached", hs_cnt - base_hs, 2);
        cycle();
        cycle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_rd_en", mem_rd_en, 0);
        chk("t5_addr", mem_addr, 0);
        chk("t5_tx", tx_data, 0);
        chk("t5_valid", slave_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        exp_q.delete();
        cycle();
        cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        do_start(8'h50, 0);
        chk("t5_restart_addr", mem_addr, 8'h50);
        wait_done("t5_done_after");
        cycle();
        cycle();
        chk("t5_queue_empty", exp_q.size(), 0);

        base_hs = hs_cnt;
        do_start(8'h60, 1);
        for (int i = 0; i < 4; i++) cycle();
        start_addr = 8'h70;
        burst_num  = 5;
        start      = 1'b1;
        cycle();
        start = 1'b0;
        wait_done("t6_done");
        cycle();
        cycle();
        chk("t6_handshakes", hs_cnt - base_hs, 2);
        chk("t6_queue_empty", exp_q.size(), 0);
        chk("t6_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
